fsm_seq_checker: RTL and testbench

- Observer and checker on the far side of the 4-state sequencer interface (start_fsm in, cs_fsm out; IDLE=0, FIRST=1, SECOND=2, LAST=3).
- Holds a cycle-accurate reference model of the legal sequence IDLE -(start)-> FIRST -> SECOND -> LAST -> IDLE.
- Compares the model to the observed cs_fsm every clock, classifies each deviation, and counts completed sequences and errors.
- Instantiated next to the sequencer in both the RTL top and the testbench. Purely passive: it drives nothing back into the sequencer.

---
 rtl/fsm_seq_checker.sv | 127 ++++++++++++
 tb/tb_fsm_seq_checker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fsm_seq_checker.sv
// Passive checker for the 4-state sequencer: a reference model tracks the
// legal IDLE->FIRST->SECOND->LAST loop and flags, classifies and counts deviations.
module fsm_seq_checker #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_fsm,
    input  logic [1:0]       cs_fsm,
    input  logic             clr,
    output logic [1:0]       exp_state,
    output logic             done_pulse,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        LAST   = 2'd3
    } state_e;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_STUCK = 2'b01;
    localparam logic [1:0] CODE_WRONG = 2'b10;
    localparam logic [1:0] CODE_SPUR  = 2'b11;

    state_e           exp_q, exp_d;
    state_e           prev_q;
    state_e           obs;
    logic             match;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [ERR_W-1:0] errc_q, errc_d;

    function automatic state_e nxt(input state_e s, input logic st);
        state_e r;
        r = IDLE;
        unique case (s)
            IDLE:   r = st ? FIRST : IDLE;
            FIRST:  r = SECOND;
            SECOND: r = LAST;
            LAST:   r = IDLE;
        endcase
        return r;
    endfunction

    assign obs = state_e'(cs_fsm);

    always_comb begin
        match    = (obs == exp_q);
        exp_d    = IDLE;
        done_d   = match && (obs == LAST);
        err_d    = !match;
        code_d   = code_q;
        sticky_d = sticky_q;
        seq_d    = seq_q;
        errc_d   = errc_q;

        // On a mismatch resync to the observed state so one fault counts once
        if (match)
            exp_d = nxt(exp_q, start_fsm);
        else
            exp_d = nxt(obs, start_fsm);

        if (!match) begin
            if (exp_q == IDLE && obs != IDLE)
                code_d = CODE_SPUR;
            else if (obs == prev_q)
                code_d = CODE_STUCK;
            else
                code_d = CODE_WRONG;
            sticky_d = 1'b1;
            if (errc_q != {ERR_W{1'b1}})
                errc_d = errc_q + ERR_W'(1);
        end

        if (done_d)
            seq_d = seq_q + CNT_W'(1);

        if (clr) begin
            code_d   = CODE_NONE;
            sticky_d = 1'b0;
            seq_d    = '0;
            errc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q    <= IDLE;
            prev_q   <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= CODE_NONE;
            sticky_q <= 1'b0;
            seq_q    <= '0;
            errc_q   <= '0;
        end else begin
            exp_q    <= exp_d;
            prev_q   <= obs;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            seq_q    <= seq_d;
            errc_q   <= errc_d;
        end
    end

    assign exp_state  = exp_q;
    assign done_pulse = done_q;
    assign err_pulse  = err_q;
    assign err_code   = code_q;
    assign err_sticky = sticky_q;
    assign seq_cnt    = seq_q;
    assign err_cnt    = errc_q;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Scoreboard bench for fsm_seq_checker: directed vectors push expected
// outputs, a monitor pops and compares one entry after every clock edge.
module tb_fsm_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       start_fsm;
    logic [1:0] cs_fsm;
    logic       clr;
    logic [1:0] exp_state;
    logic       done_pulse;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       err_sticky;
    logic [7:0] seq_cnt;
    logic [7:0] err_cnt;

    fsm_seq_checker #(.CNT_W(8), .ERR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_fsm  (start_fsm),
        .cs_fsm     (cs_fsm),
        .clr        (clr),
        .exp_state  (exp_state),
        .done_pulse (done_pulse),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .seq_cnt    (seq_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {exp_state, done, err, code, sticky, seq_cnt, err_cnt}
    logic [23:0] sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic v(input logic r, input logic s, input logic [1:0] c,
                     input logic cl, input logic [1:0] ex, input logic d,
                     input logic e, input logic [1:0] cd, input logic st,
                     input int sq, input int ec);
        @(negedge clk);
        rst_n     = r;
        start_fsm = s;
        cs_fsm    = c;
        clr       = cl;
        sb_q.push_back({ex, d, e, cd, st, sq[7:0], ec[7:0]});
    endtask

    // Monitor: outputs settle just after each posedge
    initial begin
        logic [23:0] want;
        logic [23:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                want = sb_q.pop_front();
                got  = {exp_state, done_pulse, err_pulse, err_code,
                        err_sticky, seq_cnt, err_cnt};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t got exp=%0d done=%0b err=%0b code=%0d stk=%0b seq=%0d errc=%0d want exp=%0d done=%0b err=%0b code=%0d stk=%0b seq=%0d errc=%0d",
                             n_vec, $time, got[23:22], got[21], got[20],
                             got[19:18], got[17], got[15:8], got[7:0],
                             want[23:22], want[21], want[20], want[19:18],
                             want[17], want[15:8], want[7:0]);
                end
            end
        end
    end

    initial begin
        int k;
        int lim;
        rst_n = 1'b0;
        start_fsm = 1'b0;
        cs_fsm = 2'd0;
        clr = 1'b0;

        // Single start pulse
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v(1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        v(1, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Start held high: period-4 loop
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            v(1, 1, 2'(i % 4), 0, 2'((i + 1) % 4), (i % 4) == 3, 0, 0, 0,
              (i / 4) + ((i % 4) == 3 ? 1 : 0), 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);

        // Sequencer stuck at FIRST for 3 cycles
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v(1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        v(1, 0, 1, 0, 2, 0, 1, 1, 1, 0, 1);
        v(1, 0, 1, 0, 2, 0, 1, 1, 1, 0, 2);
        v(1, 0, 2, 0, 3, 0, 0, 1, 1, 0, 2);
        v(1, 0, 3, 0, 0, 1, 0, 1, 1, 1, 2);
        v(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2);

        // Spurious jump IDLE -> SECOND, then resync
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 2, 0, 3, 0, 1, 3, 1, 0, 1);
        v(1, 0, 3, 0, 0, 1, 0, 3, 1, 1, 1);
        v(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1);

        // 300 consecutive mismatches saturate err_cnt
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            k = i;
            lim = (k > 255) ? 255 : k;
            v(1, 0, 1, 0, 2, 0, 1, (i == 1) ? 2'd3 : 2'd1, 1, 0, lim);
        end
        // clr beats the same-cycle mismatch but the pulse survives
        v(1, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0);
        v(1, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Reset mid-sequence with cs_fsm=SECOND
        v(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        v(1, 0, 1, 0, 2, 0, 0, 0, 0, 1, 0);
        v(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
